simple_uart_tx_fifo: RTL and testbench
======================================

SIMPLE_UART_TX_FIFO -- requirements
Module: simple_uart_tx_fifo

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 4; FIFO holds 2**DEPTH_LOG2 bytes.
REQ-002 SHALL have port clock, input, 1, single system clock; all logic on its rising edge.
REQ-003 SHALL have port srst, input, 1, reset, synchronous, active-high.
REQ-004 SHALL have port wr_data, input, 8, byte to enqueue.
REQ-005 SHALL have port wr_en, input, 1, enqueue strobe, one byte per cycle.
REQ-006 SHALL have port full, output, 1, high when level equals 2**DEPTH_LOG2.
REQ-007 SHALL have port empty, output, 1, high when level equals 0.
REQ-008 SHALL have port level, output, DEPTH_LOG2+1, number of bytes stored.
REQ-009 SHALL have port overflow, output, 1, one-cycle pulse when wr_en is dropped because full.
REQ-010 SHALL have port tx_value, output, 8, byte presented to the UART transmitter.
REQ-011 SHALL have port tx_value_write, output, 1, one-cycle write strobe to the UART transmitter.
REQ-012 SHALL have port tx_value_done, input, 1, one-cycle pulse from the transmitter when the stop bit of the current byte completes.

Function
REQ-013 SHALL store bytes in a circular buffer with DEPTH_LOG2-bit read/write pointers wrapping modulo 2**DEPTH_LOG2.
REQ-014 SHALL accept wr_data when wr_en=1 and full=0; level, full and empty update on the following cycle.
REQ-015 SHALL drop wr_en while full=1, even if a pop occurs in the same cycle, and SHALL pulse overflow on the next cycle.
REQ-016 SHALL, on simultaneous accepted push and pop, leave level unchanged and advance both pointers.
REQ-017 SHALL use a three-state FSM: IDLE, WRITE, WAIT_DONE.
REQ-018 IDLE: if empty=0, SHALL register the head byte into tx_value, pop it and go to WRITE; otherwise stay.
REQ-019 WRITE: SHALL drive tx_value_write=1 for exactly this one cycle and go to WAIT_DONE.
REQ-020 WAIT_DONE: SHALL stay until tx_value_done=1, then go to IDLE.
REQ-021 SHALL ignore tx_value_done in IDLE and WRITE.
REQ-022 SHALL hold tx_value stable from WRITE until the next IDLE->WRITE transition.
REQ-023 SHALL drive tx_value_write on the second rising edge after a wr_en sampled into an empty, idle FIFO, so it is high during the cycle after that edge.
REQ-024 SHALL keep a minimum of one IDLE cycle between tx_value_done and the next tx_value_write; back-to-back bytes have a 2-cycle gap from done to write.
REQ-025 SHALL preserve byte order: bytes reach tx_value in enqueue order.

Reset
REQ-026 While srst=1 at a clock edge, SHALL clear pointers, set level=0, empty=1, full=0, overflow=0, tx_value=8'h00, tx_value_write=0, state=IDLE.
REQ-027 srst asserted mid-transfer SHALL discard all queued bytes and the in-flight WAIT_DONE; no tx_value_write SHALL follow until a new byte is enqueued after reset release.
REQ-028 wr_en asserted in the same cycle as srst=1 SHALL be ignored.

Verification
REQ-029 Reset, then wr_en with wr_data=8'hA5 once -> tx_value=8'hA5 and tx_value_write pulses 1 cycle, two edges later; level returns to 0.
REQ-030 Enqueue 8'h01,8'h02,8'h03 back-to-back, done pulse 10 cycles after each write -> three write pulses in order 01,02,03, each 2 cycles after the prior done.
REQ-031 DEPTH_LOG2=4, hold tx_value_done=0, push 17 bytes -> full=1 after 16 accepted (level=16), 17th dropped with one overflow pulse.
REQ-032 At full, push and the FSM pop in the same cycle -> push dropped, overflow pulses, level becomes 15.
REQ-033 Five bytes queued, srst pulsed during WAIT_DONE -> level=0, empty=1, tx_value_write stays 0 and later done pulses are ignored.
REQ-034 tx_value_done pulsed while IDLE with empty FIFO -> no state change, no write pulse.

Source files
------------

// File: rtl/simple_uart_tx_fifo.sv
// Byte FIFO feeding a UART transmitter: circular buffer plus a three-state
// hand-off FSM that presents one byte, strobes it, and waits for stop-bit done.
//
// state        | meaning
// -------------+----------------------------------------------------------
// ST_IDLE      | no byte in flight; pops the head byte when FIFO not empty
// ST_WRITE     | tx_value_write high for exactly this cycle
// ST_WAIT_DONE | byte handed over; waiting for tx_value_done from the UART
module simple_uart_tx_fifo #(
   parameter int DEPTH_LOG2 = 4
) (
   input  logic                  clock,
   input  logic                  srst,
   input  logic [7:0]            wr_data,
   input  logic                  wr_en,
   output logic                  full,
   output logic                  empty,
   output logic [DEPTH_LOG2:0]   level,
   output logic                  overflow,
   output logic [7:0]            tx_value,
   output logic                  tx_value_write,
   input  logic                  tx_value_done
);

   localparam int DEPTH = 2 ** DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0]   LVL_FULL = DEPTH;
   localparam logic [DEPTH_LOG2:0]   LVL_ONE  = 1;
   localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = 1;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WRITE,
      ST_WAIT_DONE
   } state_t;

   state_t                state_q, state_d;
   logic [7:0]            mem_q [DEPTH];
   logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
   logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
   logic [DEPTH_LOG2:0]   level_q, level_d;
   logic                  overflow_q, overflow_d;
   logic [7:0]            tx_value_q, tx_value_d;
   logic                  push;
   logic                  pop;

   assign full           = (level_q == LVL_FULL);
   assign empty          = (level_q == '0);
   assign level          = level_q;
   assign overflow       = overflow_q;
   assign tx_value       = tx_value_q;

   // A full FIFO refuses writes even when the FSM frees a slot this cycle.
   assign push       = wr_en & ~full;
   assign overflow_d = wr_en & full;

   always_comb begin
      state_d        = state_q;
      pop            = 1'b0;
      tx_value_d     = tx_value_q;
      tx_value_write = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (!empty) begin
               pop        = 1'b1;
               tx_value_d = mem_q[rd_ptr_q];
               state_d    = ST_WRITE;
            end
         end
         ST_WRITE: begin
            tx_value_write = 1'b1;
            state_d        = ST_WAIT_DONE;
         end
         ST_WAIT_DONE: begin
            if (tx_value_done) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (push) begin
         wr_ptr_d = wr_ptr_q + PTR_ONE;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
      case ({push, pop})
         2'b10:   level_d = level_q + LVL_ONE;
         2'b01:   level_d = level_q - LVL_ONE;
         default: level_d = level_q;
      endcase
   end

   always_ff @(posedge clock) begin
      if (srst) begin
         state_q    <= ST_IDLE;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level_q    <= '0;
         overflow_q <= 1'b0;
         tx_value_q <= 8'h00;
      end else begin
         state_q    <= state_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         level_q    <= level_d;
         overflow_q <= overflow_d;
         tx_value_q <= tx_value_d;
      end
   end

   always_ff @(posedge clock) begin
      if (push && !srst) begin
         mem_q[wr_ptr_q] <= wr_data;
      end
   end

endmodule

// File: tb/tb_simple_uart_tx_fifo.sv
// Directed bench for simple_uart_tx_fifo: hand-computed expectations checked
// with immediate assertions, one sample point 1 ns after each rising edge.
module tb_simple_uart_tx_fifo;

   logic       clock = 1'b0;
   logic       srst = 1'b1;
   logic [7:0] wr_data = 8'h00;
   logic       wr_en = 1'b0;
   logic       full;
   logic       empty;
   logic [4:0] level;
   logic       overflow;
   logic [7:0] tx_value;
   logic       tx_value_write;
   logic       tx_value_done = 1'b0;

   int checks = 0;
   int errors = 0;
   int t;

   simple_uart_tx_fifo #(.DEPTH_LOG2(4)) dut (
      .clock          (clock),
      .srst           (srst),
      .wr_data        (wr_data),
      .wr_en          (wr_en),
      .full           (full),
      .empty          (empty),
      .level          (level),
      .overflow       (overflow),
      .tx_value       (tx_value),
      .tx_value_write (tx_value_write),
      .tx_value_done  (tx_value_done)
   );

   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Pulse done, then count edges until the next write strobe (bounded).
   task automatic done_then_wait_write(output int n);
      tx_value_done = 1'b1;
      n = 0;
      do begin
         tick();
         tx_value_done = 1'b0;
         n++;
      end while (!tx_value_write && n < 20);
   endtask

   initial begin
      // reset with a write attempt that must be ignored
      wr_en = 1'b1; wr_data = 8'hFF;
      tick(); tick();
      srst = 1'b0; wr_en = 1'b0;
      chk("rst_level", level, 0);
      chk("rst_empty", empty, 1);
      chk("rst_full", full, 0);
      chk("rst_overflow", overflow, 0);
      chk("rst_tx_value", tx_value, 8'h00);
      chk("rst_write", tx_value_write, 0);
      tick();
      chk("rst_wr_ignored_level", level, 0);
      chk("rst_wr_ignored_write", tx_value_write, 0);

      // done while idle and empty is ignored
      tx_value_done = 1'b1;
      tick();
      tx_value_done = 1'b0;
      chk("idle_done_write", tx_value_write, 0);
      chk("idle_done_level", level, 0);
      tick();
      chk("idle_done_write2", tx_value_write, 0);

      // single byte A5
      wr_en = 1'b1; wr_data = 8'hA5;
      tick();
      wr_en = 1'b0;
      chk("a5_level1", level, 1);
      chk("a5_empty0", empty, 0);
      chk("a5_no_write_yet", tx_value_write, 0);
      tick();
      chk("a5_write", tx_value_write, 1);
      chk("a5_value", tx_value, 8'hA5);
      chk("a5_level0", level, 0);
      tick();
      chk("a5_write_one_cycle", tx_value_write, 0);
      chk("a5_value_hold", tx_value, 8'hA5);
      tx_value_done = 1'b1;
      tick();
      tx_value_done = 1'b0;
      tick();

      // three bytes back to back, done 10 cycles after each write
      wr_en = 1'b1; wr_data = 8'h01;
      tick();
      wr_data = 8'h02;
      tick();
      chk("b3_write1", tx_value_write, 1);
      chk("b3_value1", tx_value, 8'h01);
      chk("b3_level_pushpop", level, 1);
      wr_data = 8'h03;
      tick();
      wr_en = 1'b0;
      chk("b3_level2", level, 2);
      for (int i = 2; i <= 3; i++) begin
         for (int k = 0; k < 9; k++) begin
            tick();
            chk("b3_no_write_wait", tx_value_write, 0);
         end
         done_then_wait_write(t);
         chk("b3_gap", t, 2);
         chk("b3_value", tx_value, i);
      end
      for (int k = 0; k < 9; k++) tick();
      tx_value_done = 1'b1;
      tick();
      tx_value_done = 1'b0;
      tick();
      chk("b3_drained_level", level, 0);
      chk("b3_drained_empty", empty, 1);
      chk("b3_drained_write", tx_value_write, 0);

      // fill: FSM holds 0x20 in WAIT_DONE, then 17 pushes with done held low
      wr_en = 1'b1; wr_data = 8'h20;
      tick();
      wr_en = 1'b0;
      tick();
      chk("fill_head_write", tx_value_write, 1);
      chk("fill_head_value", tx_value, 8'h20);
      tick();
      for (int i = 0; i < 16; i++) begin
         wr_en = 1'b1; wr_data = 8'(8'h30 + i);
         tick();
      end
      chk("fill_level16", level, 16);
      chk("fill_full", full, 1);
      chk("fill_no_overflow", overflow, 0);
      wr_data = 8'h40;
      tick();
      wr_en = 1'b0;
      chk("fill_overflow_pulse", overflow, 1);
      chk("fill_level_held", level, 16);
      tick();
      chk("fill_overflow_end", overflow, 0);
      chk("fill_still_full", full, 1);

      // push at full in the same cycle as the FSM pop
      tx_value_done = 1'b1;
      tick();
      tx_value_done = 1'b0;
      wr_en = 1'b1; wr_data = 8'hEE;
      tick();
      wr_en = 1'b0;
      chk("pp_level15", level, 15);
      chk("pp_overflow", overflow, 1);
      chk("pp_full0", full, 0);
      chk("pp_write", tx_value_write, 1);
      chk("pp_value", tx_value, 8'h30);
      tick();
      chk("pp_overflow_end", overflow, 0);
      done_then_wait_write(t);
      chk("pp_gap", t, 2);
      chk("pp_next_value", tx_value, 8'h31);

      // reset mid-transfer
      srst = 1'b1;
      tick();
      srst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         wr_en = 1'b1; wr_data = 8'(8'h50 + i);
         tick();
      end
      wr_en = 1'b0;
      chk("mr_level4", level, 4);
      tick();
      srst = 1'b1;
      tick();
      srst = 1'b0;
      chk("mr_level0", level, 0);
      chk("mr_empty", empty, 1);
      chk("mr_tx_value", tx_value, 8'h00);
      tx_value_done = 1'b1;
      tick();
      tx_value_done = 1'b0;
      for (int k = 0; k < 5; k++) begin
         chk("mr_no_write", tx_value_write, 0);
         tick();
      end
      chk("mr_level_stays0", level, 0);
      wr_en = 1'b1; wr_data = 8'h77;
      tick();
      wr_en = 1'b0;
      tick();
      chk("mr_new_write", tx_value_write, 1);
      chk("mr_new_value", tx_value, 8'h77);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
